// File: rtl/prog_counter_blink.sv
// Programmable-modulus 74x163-style up/down counter with a duty-threshold PWM output,
// a toggle flip-flop that flips on every wrap, and a one-cycle wrap pulse.
module prog_counter_blink #(
  parameter int          N        = 26,
  parameter int unsigned TERM_RST = 49_999_999
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         ENP,
  input  logic         ENT,
  input  logic         CLRb,
  input  logic         LDb,
  input  logic         up,
  input  logic [N-1:0] D,
  input  logic         term_we,
  input  logic [N-1:0] term_in,
  input  logic [N-1:0] thresh,
  output logic [N-1:0] q,
  output logic         rco,
  output logic         pwm,
  output logic         toggle,
  output logic         wrap
);

  localparam logic [N-1:0] TERM_INIT = N'(TERM_RST);

  logic [N-1:0] count_q, count_d;
  logic [N-1:0] term_q, term_d;
  logic         toggle_q, toggle_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    term_d   = term_we ? term_in : term_q;
    count_d  = count_q;
    toggle_d = toggle_q;
    wrap_d   = 1'b0;
    if (!CLRb) begin
      count_d = '0;
    end else if (!LDb) begin
      count_d = D;
    end else if (ENP && ENT) begin
      // >= and > let the counter recover when q sits above a lowered terminal count
      if (up) begin
        if (count_q >= term_q) begin
          count_d  = '0;
          toggle_d = ~toggle_q;
          wrap_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0 || count_q > term_q) begin
          count_d  = term_q;
          toggle_d = ~toggle_q;
          wrap_d   = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      term_q   <= TERM_INIT;
      toggle_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      term_q   <= term_d;
      toggle_q <= toggle_d;
      wrap_q   <= wrap_d;
    end
  end

  assign q      = count_q;
  assign toggle = toggle_q;
  assign wrap   = wrap_q;
  assign rco    = ENT & (up ? (count_q == term_q) : (count_q == '0));
  assign pwm    = (count_q >= thresh);

endmodule

// File: tb/tb_prog_counter_blink.sv
// Self-checking bench for prog_counter_blink (N=4, TERM_RST=9): directed sequences,
// a vector table, and randomized stimulus against an arithmetic reference model.
module tb_prog_counter_blink;

  localparam int N = 4;
  localparam int TERM0 = 9;
  localparam int MAXV = (1 << N) - 1;

  logic         CLK, reset, ENP, ENT, CLRb, LDb, up, term_we;
  logic [N-1:0] D, term_in, thresh, q;
  logic         rco, pwm, toggle, wrap;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_q, m_term, m_tog, m_wrap;

  typedef struct {
    int clrb, ldb, enp, ent, upv, d, we, tin, thr;
    int eq, erco, epwm, etog, ewrap;
  } vec_t;
  vec_t vq[$];

  prog_counter_blink #(.N(N), .TERM_RST(TERM0)) dut (
    .CLK(CLK), .reset(reset), .ENP(ENP), .ENT(ENT), .CLRb(CLRb), .LDb(LDb),
    .up(up), .D(D), .term_we(term_we), .term_in(term_in), .thresh(thresh),
    .q(q), .rco(rco), .pwm(pwm), .toggle(toggle), .wrap(wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eq, input int erco, input int epwm,
                         input int etog, input int ewrap);
    chk({tag, " q"}, int'(q), eq);
    chk({tag, " rco"}, int'(rco), erco);
    chk({tag, " pwm"}, int'(pwm), epwm);
    chk({tag, " toggle"}, int'(toggle), etog);
    chk({tag, " wrap"}, int'(wrap), ewrap);
  endtask

  task automatic set_in(input int clrb, input int ldb, input int enp, input int ent,
                        input int upv, input int d, input int we, input int tin, input int thr);
    CLRb = clrb[0]; LDb = ldb[0]; ENP = enp[0]; ENT = ent[0]; up = upv[0];
    D = d[N-1:0]; term_we = we[0]; term_in = tin[N-1:0]; thresh = thr[N-1:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    m_q = 0; m_term = TERM0; m_tog = 0; m_wrap = 0;
  endtask

  // Model of one rising edge: the period is term+1 states, wrap re-enters the cycle.
  task automatic model_edge();
    int nq, nt, ntog, nw;
    nq = m_q; ntog = m_tog; nw = 0;
    nt = term_we ? int'(term_in) : m_term;
    if (!CLRb) nq = 0;
    else if (!LDb) nq = int'(D);
    else if (ENP && ENT) begin
      if (up) begin
        if (m_q < m_term) nq = m_q + 1;
        else begin nq = 0; nw = 1; end
      end else begin
        if (m_q >= 1 && m_q <= m_term) nq = m_q - 1;
        else begin nq = m_term; nw = 1; end
      end
      if (nw) ntog = 1 - m_tog;
    end
    m_q = nq; m_term = nt; m_tog = ntog; m_wrap = nw;
  endtask

  task automatic step_model(input string tag);
    int erco;
    model_edge();
    @(posedge CLK);
    #1;
    erco = ENT ? (up ? int'(m_q == m_term) : int'(m_q == 0)) : 0;
    chk_all(tag, m_q, erco, int'(m_q >= int'(thresh)), m_tog, m_wrap);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 1, 0, 0, 1, 0, 0, 0, 5);
    do_reset();

    // reset state
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);

    // 25 enabled up-count edges: q = i mod 10, toggle flips every 10 edges
    set_in(1, 1, 1, 1, 1, 0, 0, 0, 5);
    for (int i = 1; i <= 25; i++) begin
      @(posedge CLK);
      #1;
      chk_all($sformatf("run%0d", i), i % 10, int'(i % 10 == 9), int'(i % 10 >= 5),
              (i / 10) % 2, int'(i % 10 == 0));
    end

    // directed vector table, applied from a fresh reset
    //            clr ld enp ent up  d we tin thr   q rco pwm tog wrap
    vq.push_back('{1, 0, 0, 0, 1,  3, 0, 0, 5,    3, 0, 0, 0, 0});
    vq.push_back('{0, 0, 1, 1, 1,  7, 0, 0, 5,    0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 0, 1, 1,  7, 0, 0, 5,    7, 0, 1, 0, 0});
    vq.push_back('{1, 0, 0, 1, 1, 13, 0, 0, 5,   13, 0, 1, 0, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    0, 0, 0, 1, 1});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    1, 0, 0, 1, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    2, 0, 0, 1, 0});
    vq.push_back('{1, 1, 1, 1, 0,  0, 0, 0, 5,    1, 0, 0, 1, 0});
    vq.push_back('{1, 1, 1, 1, 0,  0, 0, 0, 5,    0, 1, 0, 1, 0});
    vq.push_back('{1, 1, 0, 0, 0,  0, 0, 0, 5,    0, 0, 0, 1, 0});
    vq.push_back('{1, 1, 1, 1, 0,  0, 0, 0, 5,    9, 0, 1, 0, 1});
    vq.push_back('{1, 1, 1, 1, 0,  0, 0, 0, 5,    8, 0, 1, 0, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 0,    9, 1, 1, 0, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 12,   0, 0, 0, 1, 1});
    vq.push_back('{1, 0, 0, 0, 1,  6, 0, 0, 5,    6, 0, 1, 1, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 1, 3, 5,    7, 0, 1, 1, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    0, 0, 0, 0, 1});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    1, 0, 0, 0, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 1, 0, 5,    2, 0, 0, 0, 0});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    0, 1, 0, 1, 1});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    0, 1, 0, 0, 1});
    vq.push_back('{1, 1, 1, 1, 1,  0, 0, 0, 5,    0, 1, 0, 1, 1});
    vq.push_back('{1, 1, 0, 1, 1,  0, 0, 0, 5,    0, 1, 0, 1, 0});
    vq.push_back('{1, 1, 0, 0, 1,  0, 1, 9, 5,    0, 0, 0, 1, 0});
    do_reset();
    foreach (vq[i]) begin
      set_in(vq[i].clrb, vq[i].ldb, vq[i].enp, vq[i].ent, vq[i].upv, vq[i].d,
             vq[i].we, vq[i].tin, vq[i].thr);
      @(posedge CLK);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].eq, vq[i].erco, vq[i].epwm, vq[i].etog, vq[i].ewrap);
    end

    // randomized stimulus against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(int'($urandom_range(0, 19) != 0), int'($urandom_range(0, 11) != 0),
             int'($urandom_range(0, 5) != 0), int'($urandom_range(0, 5) != 0),
             int'($urandom_range(0, 3) != 0), int'($urandom_range(0, MAXV)),
             int'($urandom_range(0, 15) == 0), int'($urandom_range(0, MAXV)),
             int'($urandom_range(0, MAXV)));
      step_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset mid-run: get toggle=1, wrap=1, q=1 first, then reset between edges
    set_in(1, 1, 0, 0, 0, 0, 1, 1, 5);
    step_model("prep_term");
    set_in(1, 1, 1, 1, 0, 0, 0, 0, 5);
    begin
      int n;
      n = 0;
      do begin
        step_model($sformatf("prep%0d", n));
        n++;
      end while (!(m_wrap == 1 && m_tog == 1) && n < 8);
      chk("prep_reached", int'(m_wrap == 1 && m_tog == 1), 1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst q", int'(q), 0);
    chk("async_rst toggle", int'(toggle), 0);
    chk("async_rst wrap", int'(wrap), 0);
    @(negedge CLK);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_counter_blink.md
Name: prog_counter_blink

Overview:
Parametrised N-bit 74x163-style synchronous counter with ENP/ENT enables, synchronous active-low clear and load, and an up/down mode. It adds a runtime-programmable terminal count (modulo), a runtime-programmable duty threshold (PWM/blink output) and a wrap-toggle flip-flop output. It supersedes the fixed 26-bit counter. Top level ties CLK to the 50 MHz board clock: term=49_999_999 and thresh=25_000_000 give a 1 Hz LED with 50% duty, and the toggle output drives Arduino IO0 for scope measurement.

Parameters:
N, 26, counter width in bits (N >= 2)
TERM_RST, 49_999_999, reset value of the internal terminal-count register (must fit in N bits)

Ports:
CLK  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
ENP  input  1  count enable P
ENT  input  1  count enable T; also gates rco
CLRb  input  1  synchronous clear, active-low
LDb  input  1  synchronous parallel load, active-low
up  input  1  1 = count up, 0 = count down
D  input  N  parallel load value
term_we  input  1  write strobe for the terminal-count register
term_in  input  N  new terminal count
thresh  input  N  duty threshold (combinational compare input)
q  output  N  current count
rco  output  1  ripple-carry out
pwm  output  1  duty output
toggle  output  1  toggles on every wrap
wrap  output  1  one-cycle registered pulse following a wrap

Behaviour:
- Reset is asynchronous and active-high. It forces q=0, toggle=0, wrap=0 and term_reg=TERM_RST, and it overrides everything. Release is synchronous to CLK by the instantiator.
- term_reg update: if term_we=1 at a rising edge, term_reg <= term_in. The new value takes effect from the next cycle. This update is independent of the count priority below.
- Count priority at each rising edge, highest first:
  1. CLRb=0: q <= 0. Enables are ignored; toggle holds; wrap <= 0.
  2. LDb=0: q <= D. D is loaded as-is even when D > term_reg. toggle holds; wrap <= 0.
  3. ENP=1 and ENT=1, up=1:
     - q >= term_reg: q <= 0, toggle <= ~toggle, wrap <= 1.
     - otherwise: q <= q+1, wrap <= 0.
  4. ENP=1 and ENT=1, up=0:
     - q == 0 or q > term_reg: q <= term_reg, toggle <= ~toggle, wrap <= 1.
     - otherwise: q <= q-1, wrap <= 0.
  5. Otherwise: q, toggle and term_reg hold; wrap <= 0.
- The >= and > comparisons make the counter recover after term_reg is lowered below q or after an out-of-range load. It never runs on to 2^N-1.
- rco (combinational) = ENT & (up ? (q == term_reg) : (q == 0)). It does not depend on ENP, CLRb or LDb, matching 74x163 semantics.
- pwm (combinational) = (q >= thresh).
  - thresh=0 gives pwm constantly 1.
  - thresh > term_reg gives pwm constantly 0 in steady up-counting.
  - High time per period is term_reg-thresh+1 cycles.
- Period when continuously enabled is term_reg+1 cycles.
  - toggle frequency = f_CLK / (2·(term_reg+1)).
  - term_reg=0: q stays 0, rco=ENT, and toggle flips every enabled cycle (f_CLK/2).
- Arithmetic is unsigned N-bit with no wrap through 2^N. Reaching 2^N-1 requires term_reg=2^N-1, which is legal and wraps to 0.
- Latency: q, toggle and wrap change one edge after the qualifying inputs. rco and pwm follow q combinationally.
- Mid-count mode change (up toggled): the next enabled edge applies the new direction from the current q, with no glitch state.

Test Plan:
- N=4, TERM_RST=9, up=1, ENP=ENT=1 for 25 cycles → q runs 0..9,0..9,0..4. rco is high exactly while q=9. Wrap pulses on the cycles after q 9→0. toggle=0 at the end (two wraps).
- Same setup, thresh=5 → pwm low for q=0..4 and high for q=5..9 (50% duty). Then thresh=0 → pwm stuck 1; thresh=12 → pwm stuck 0.
- N=4, q=3, assert CLRb=0 and LDb=0 together with D=7 → q=0 next edge (clear wins). Next edge with CLRb=1, LDb=0, ENP=0 → q=7 (load ignores enables).
- N=4, term=9, load D=13, then count up → q=13→0 on the first enabled edge, with toggle flip and wrap=1. Then up=0 from q=2 → 2,1,0,9,8; rco high at q=0 with ENT=1 and low with ENT=0.
- While counting at q=6, write term_in=3 with term_we=1 → next edge q=7 (old term), following edge q=0 with wrap. term_in=0 → toggle flips every cycle.
- Defaults (N=26, TERM_RST=49_999_999), thresh=25_000_000, 100_000_000 cycles → toggle period 100_000_000 cycles. pwm is high for 25_000_000 cycles per 50_000_000-cycle period. Asserting reset mid-run forces q=0, toggle=0 and wrap=0 immediately, without waiting for a clock edge.
